ps2_keycode_receiver: RTL and testbench
=======================================

Name: ps2_keycode_receiver

Overview:
Receives PS/2 keyboard frames and decodes Set-2 scancodes, including E0 extended and F0 break prefixes. Produces the 16-bit keycode bus that the game logic (ball/bird control, hex display) consumes in place of the USB/Nios path. Runs entirely in the Clk domain. The asynchronous PS2_CLK and PS2_DAT lines are synchronized and glitch-filtered internally.

Parameters:
FILTER_LEN, 8, consecutive Clk cycles PS2_CLK must hold a new level before the filtered clock changes
TIMEOUT_CYCLES, 50000, idle Clk cycles mid-frame before the frame is aborted (1 ms at 50 MHz)

Ports:
Clk  in  1  system clock (CLOCK_50)
Reset  in  1  synchronous, active-high reset
PS2_CLK  in  1  PS/2 clock line, asynchronous
PS2_DAT  in  1  PS/2 data line, asynchronous
byte_data  out  8  last correctly received byte
byte_valid  out  1  one-cycle pulse when byte_data updates
frame_err  out  1  one-cycle pulse on parity, stop-bit or timeout error
key_event  out  1  one-cycle pulse per decoded make/break
key_make  out  1  1 = make, 0 = break; valid when key_event is high
key_extended  out  1  event carried the E0 prefix
key_code  out  8  scancode of the event
keycode  out  16  currently held key: {E0 or 00, code}; 0x0000 when none is held

Behaviour:
- Interface: one clock, Clk. Reset is synchronous and active-high. Sync flops and the filtered clock reset to 1; everything else resets to 0.
- Reset values: all outputs 0; frame FSM in IDLE; both prefix flags cleared. Reset mid-frame discards any partial byte.
- Sync: 2-FF synchronizer on each line. Filter: a counter increments while the synchronized clock differs from the filtered clock and clears when they match; at FILTER_LEN-1 the filtered clock takes the new level.
- Sample event: a 1→0 transition of the filtered clock. Data is taken from the synchronized PS2_DAT in that same cycle.
- Frame FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a sample with dat=0, go to DATA with bit_cnt=0. A sample with dat=1 is ignored.
  - DATA: shift data in LSB first; after the 8th sample go to PARITY.
  - PARITY: latch the parity bit; go to STOP.
  - STOP: if stop=1 and the ones-count of data plus parity is odd, byte_valid pulses and byte_data loads; otherwise frame_err pulses. Always return to IDLE.
- Latency: byte_valid/frame_err assert 1 cycle after the stop-bit sample event.
- Timeout: the counter clears on every sample event and in IDLE. In any state other than IDLE, reaching TIMEOUT_CYCLES-1 pulses frame_err and returns to IDLE. The partial byte is dropped.
- Decoder, on byte_valid:
  - E0 sets ext_pending.
  - F0 sets brk_pending.
  - AA, FA, EE, FE, 00, FF, E1 clear both flags and generate no event.
  - Any other byte: key_event pulses 1 cycle after byte_valid, with key_code=byte, key_extended=ext_pending, key_make=~brk_pending. Both flags then clear.
- frame_err also clears both prefix flags.
- keycode updates in the same cycle key_event asserts:
  - Make: keycode = {ext ? 8'hE0 : 8'h00, code}.
  - Break: clear to 0 only if {prefix, code} equals keycode; otherwise hold.
  - Typematic repeat of the held key leaves keycode unchanged.
- Simultaneous events: a timeout and a sample event in the same cycle resolve as the sample (the timer clears). Outputs are never combinational from the PS/2 pins.

Decomposition:
- Package ps2_pkg:
  - frame state enum: IDLE, DATA, PARITY, STOP
  - constants: PS2_EXT=8'hE0, PS2_BREAK=8'hF0, PS2_BAT_OK=8'hAA, PS2_ACK=8'hFA, PS2_ECHO=8'hEE, PS2_RESEND=8'hFE, PS2_PAUSE=8'hE1
- Sub-module ps2_frame_rx: sync, filter, frame FSM, timeout. Outputs byte_data, byte_valid and frame_err.
- The top level holds the prefix decoder and the keycode register.

Test Plan:
Bench parameters: FILTER_LEN=4, TIMEOUT_CYCLES=1000, PS/2 half-period of 100 Clk cycles.
1. Send frame 0x29 with parity 0 → byte_valid with byte_data=0x29; next cycle key_event with key_make=1 and key_extended=0; keycode=0x0029.
2. Send 0x1C, then 0x23, then F0 1C → keycode goes 0x001C, then 0x0023, and stays 0x0023 on the 0x1C break (key_make=0); F0 23 then gives 0x0000.
3. Send E0 75, then E0 F0 75 → keycode 0xE075 with key_extended=1; after the break keycode=0x0000 and exactly two key_events have occurred.
4. Send 0x1C with parity bit 1 → frame_err pulse, no byte_valid, keycode unchanged. Then send F0 with a bad stop bit followed by 0x1C → make event for 0x1C, not break.
5. Send a start bit plus 4 data bits, then idle 1000 cycles → frame_err pulse and FSM back in IDLE. A following clean 0x1C frame decodes correctly.
6. Inject a 2-cycle low glitch on PS2_CLK → no bit sampled and no outputs toggle. Assert Reset mid-frame → all outputs 0 on the next cycle, and a subsequent clean frame decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared frame states, scancode constants and helpers for the PS/2 receiver
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } frame_state_t;

  localparam logic [7:0] PS2_EXT      = 8'hE0;
  localparam logic [7:0] PS2_BREAK    = 8'hF0;
  localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_ACK      = 8'hFA;
  localparam logic [7:0] PS2_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_PAUSE    = 8'hE1;
  localparam logic [7:0] PS2_ERR_LOW  = 8'h00;
  localparam logic [7:0] PS2_ERR_HIGH = 8'hFF;

  // Keyboard status/response bytes that must never become key events.
  function automatic logic is_system_byte(input logic [7:0] b);
    return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
           (b == PS2_RESEND) || (b == PS2_PAUSE) ||
           (b == PS2_ERR_LOW) || (b == PS2_ERR_HIGH);
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line sync, clock glitch filter, 11-bit frame FSM and timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt_clk, filt_clk_d;
  logic [FW-1:0] filt_cnt;
  logic          sample;

  frame_state_t  state, next_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          valid_nxt, err_nxt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      clk_s1     <= 1'b1;
      clk_s2     <= 1'b1;
      dat_s1     <= 1'b1;
      dat_s2     <= 1'b1;
      filt_clk   <= 1'b1;
      filt_clk_d <= 1'b1;
      filt_cnt   <= '0;
    end else begin
      clk_s1     <= PS2_CLK;
      clk_s2     <= clk_s1;
      dat_s1     <= PS2_DAT;
      dat_s2     <= dat_s1;
      filt_clk_d <= filt_clk;
      if (clk_s2 != filt_clk) begin
        if (filt_cnt == FILT_MAX) begin
          filt_clk <= clk_s2;
          filt_cnt <= '0;
        end else begin
          filt_cnt <= filt_cnt + 1'b1;
        end
      end else begin
        filt_cnt <= '0;
      end
    end
  end

  assign sample  = filt_clk_d & ~filt_clk;
  assign timeout = (state != IDLE) && (timer == TIME_MAX);

  always_comb begin
    next_state = state;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      IDLE:    if (sample && !dat_s2) next_state = DATA;
      DATA:    if (sample && bit_cnt == 3'd7) next_state = PARITY;
      PARITY:  if (sample) next_state = STOP;
      STOP: begin
        if (sample) begin
          next_state = IDLE;
          // Odd parity: data ones plus the parity bit must be odd.
          if (dat_s2 && (^{shift, par})) valid_nxt = 1'b1;
          else                           err_nxt   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
    if (!sample && timeout) begin
      next_state = IDLE;
      err_nxt    = 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      par        <= 1'b0;
      timer      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= next_state;
      byte_valid <= valid_nxt;
      frame_err  <= err_nxt;
      if (valid_nxt) byte_data <= shift;
      if (sample || state == IDLE) timer <= '0;
      else                         timer <= timer + 1'b1;
      if (sample) begin
        case (state)
          IDLE:   bit_cnt <= '0;
          DATA: begin
            shift   <= {dat_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par <= dat_s2;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_keycode_receiver.sv
// rtl/ps2_keycode_receiver.sv - Set-2 scancode decoder with E0/F0 prefixes and held-key register
module ps2_keycode_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic        frame_err,
  output logic        key_event,
  output logic        key_make,
  output logic        key_extended,
  output logic [7:0]  key_code,
  output logic [15:0] keycode
);

  logic        ext_pending, brk_pending;
  logic [15:0] event_key;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .Clk       (Clk),
    .Reset     (Reset),
    .PS2_CLK   (PS2_CLK),
    .PS2_DAT   (PS2_DAT),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  assign event_key = {(ext_pending ? PS2_EXT : 8'h00), byte_data};

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ext_pending  <= 1'b0;
      brk_pending  <= 1'b0;
      key_event    <= 1'b0;
      key_make     <= 1'b0;
      key_extended <= 1'b0;
      key_code     <= '0;
      keycode      <= '0;
    end else begin
      key_event <= 1'b0;
      if (frame_err) begin
        ext_pending <= 1'b0;
        brk_pending <= 1'b0;
      end else if (byte_valid) begin
        if (byte_data == PS2_EXT) begin
          ext_pending <= 1'b1;
        end else if (byte_data == PS2_BREAK) begin
          brk_pending <= 1'b1;
        end else begin
          ext_pending <= 1'b0;
          brk_pending <= 1'b0;
          if (!is_system_byte(byte_data)) begin
            key_event    <= 1'b1;
            key_code     <= byte_data;
            key_extended <= ext_pending;
            key_make     <= ~brk_pending;
            // Releasing a key other than the held one leaves the held key in place.
            if (!brk_pending)            keycode <= event_key;
            else if (event_key == keycode) keycode <= '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_receiver.sv
// tb/tb_ps2_keycode_receiver.sv - directed self-checking bench for ps2_keycode_receiver
module tb_ps2_keycode_receiver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        PS2_CLK = 1'b1;
  logic        PS2_DAT = 1'b1;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        frame_err;
  logic        key_event;
  logic        key_make;
  logic        key_extended;
  logic [7:0]  key_code;
  logic [15:0] keycode;

  int checks = 0;
  int errors = 0;

  int          bv_cnt = 0, err_cnt = 0, ev_cnt = 0;
  logic [7:0]  last_byte = 8'h00, last_code = 8'h00;
  logic        last_make = 1'b0, last_ext = 1'b0, ev_after_bv = 1'b0;
  logic        bv_prev = 1'b0;
  logic [15:0] keycode_at_ev = 16'h0000;

  int bv0, err0, ev0;

  ps2_keycode_receiver #(
    .FILTER_LEN    (4),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PS2_CLK     (PS2_CLK),
    .PS2_DAT     (PS2_DAT),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .frame_err   (frame_err),
    .key_event   (key_event),
    .key_make    (key_make),
    .key_extended(key_extended),
    .key_code    (key_code),
    .keycode     (keycode)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (byte_valid) begin
      bv_cnt++;
      last_byte = byte_data;
    end
    if (frame_err) err_cnt++;
    if (key_event) begin
      ev_cnt++;
      last_code     = key_code;
      last_make     = key_make;
      last_ext      = key_extended;
      ev_after_bv   = bv_prev;
      keycode_at_ev = keycode;
    end
    bv_prev = byte_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic send_bit(input logic b);
    PS2_DAT = b;
    wait_cycles(50);
    PS2_CLK = 1'b0;
    wait_cycles(100);
    PS2_CLK = 1'b1;
    wait_cycles(50);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit((~^d) ^ par_flip);
    send_bit(stop);
    wait_cycles(20);
  endtask

  task automatic send_good(input logic [7:0] d);
    send_frame(d, 1'b0, 1'b1);
  endtask

  task automatic snap();
    bv0  = bv_cnt;
    err0 = err_cnt;
    ev0  = ev_cnt;
  endtask

  initial begin
    wait_cycles(5);
    check("reset_keycode", keycode, 16'h0000);
    check("reset_byte_data", byte_data, 8'h00);
    check("reset_pulses", {byte_valid, frame_err, key_event, key_make, key_extended}, 5'b0);
    Reset = 1'b0;
    wait_cycles(20);

    // 1: single make
    snap();
    send_good(8'h29);
    check("t1_bv_cnt", bv_cnt - bv0, 1);
    check("t1_byte", last_byte, 8'h29);
    check("t1_ev_cnt", ev_cnt - ev0, 1);
    check("t1_ev_latency", ev_after_bv, 1'b1);
    check("t1_make_ext", {last_make, last_ext}, 2'b10);
    check("t1_keycode_at_ev", keycode_at_ev, 16'h0029);
    check("t1_keycode", keycode, 16'h0029);

    // 2: held key replacement and mismatched break
    send_good(8'h1C);
    check("t2_keycode_1c", keycode, 16'h001C);
    send_good(8'h23);
    check("t2_keycode_23", keycode, 16'h0023);
    send_good(8'hF0);
    send_good(8'h1C);
    check("t2_break_1c_make", last_make, 1'b0);
    check("t2_break_1c_code", last_code, 8'h1C);
    check("t2_keycode_hold", keycode, 16'h0023);
    send_good(8'hF0);
    send_good(8'h23);
    check("t2_keycode_clear", keycode, 16'h0000);

    // 3: extended make and break
    snap();
    send_good(8'hE0);
    send_good(8'h75);
    check("t3_keycode_e075", keycode, 16'hE075);
    check("t3_ext", last_ext, 1'b1);
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    check("t3_break_ext_make", {last_ext, last_make}, 2'b10);
    check("t3_keycode_clear", keycode, 16'h0000);
    check("t3_ev_cnt", ev_cnt - ev0, 2);
    check("t3_bv_cnt", bv_cnt - bv0, 5);

    // 4: parity error, then bad stop bit clears a pending break
    snap();
    send_frame(8'h1C, 1'b1, 1'b1);
    check("t4_par_err", err_cnt - err0, 1);
    check("t4_par_bv", bv_cnt - bv0, 0);
    check("t4_par_keycode", keycode, 16'h0000);
    send_frame(8'hF0, 1'b0, 1'b0);
    check("t4_stop_err", err_cnt - err0, 2);
    send_good(8'h1C);
    check("t4_make_after_err", last_make, 1'b1);
    check("t4_keycode", keycode, 16'h001C);
    check("t4_ev_cnt", ev_cnt - ev0, 1);

    // 4b: system byte produces no event
    snap();
    send_good(8'hAA);
    check("t4_sys_bv", bv_cnt - bv0, 1);
    check("t4_sys_ev", ev_cnt - ev0, 0);

    // 5: timeout on partial frame
    snap();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    wait_cycles(1200);
    check("t5_timeout_err", err_cnt - err0, 1);
    check("t5_timeout_bv", bv_cnt - bv0, 0);
    send_good(8'h23);
    check("t5_after_byte", last_byte, 8'h23);
    check("t5_after_keycode", keycode, 16'h0023);
    check("t5_after_err", err_cnt - err0, 1);

    // 6: glitch on PS2_CLK, then a clean frame stays aligned
    snap();
    PS2_CLK = 1'b0;
    wait_cycles(2);
    PS2_CLK = 1'b1;
    wait_cycles(200);
    check("t6_glitch_pulses", (bv_cnt - bv0) + (err_cnt - err0) + (ev_cnt - ev0), 0);
    check("t6_glitch_keycode", keycode, 16'h0023);
    send_good(8'h1C);
    check("t6_clean_byte", last_byte, 8'h1C);
    check("t6_clean_keycode", keycode, 16'h001C);
    check("t6_clean_err", err_cnt - err0, 0);

    // 6b: reset mid-frame
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    Reset = 1'b1;
    wait_cycles(1);
    check("t6_rst_keycode", keycode, 16'h0000);
    check("t6_rst_byte", byte_data, 8'h00);
    check("t6_rst_pulses", {byte_valid, frame_err, key_event, key_make, key_extended, key_code}, 13'h0);
    Reset = 1'b0;
    wait_cycles(20);
    snap();
    send_good(8'h29);
    check("t6_post_rst_byte", last_byte, 8'h29);
    check("t6_post_rst_keycode", keycode, 16'h0029);
    check("t6_post_rst_err", err_cnt - err0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
